pipe_issue_unit: RTL and testbench
==================================

Name: pipe_issue_unit

Overview:
- Instruction issue front-end for the 4-stage register/ALU/memory pipeline.
- Holds a small program of pipeline instructions. On start, drives the pipeline's rs1/rs2/rd/func/addr inputs at most one instruction per clock.
- Inserts bubbles on read-after-write hazards against instructions still in flight.
- Signals completion once the last instruction has retired to memory.

Parameters:
- IMEM_DEPTH, 16: number of 24-bit instruction slots; power of two.
- LAT, 3: minimum issue-cycle distance from a producer (rd) to a dependent consumer (rs1/rs2); 1..4.

Ports:
- clk1  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- load_en  input  1  write one instruction slot; honoured only in IDLE.
- load_addr  input  4  slot index, log2(IMEM_DEPTH).
- load_data  input  24  instruction, packed {rs1[23:20], rs2[19:16], rd[15:12], func[11:8], addr[7:0]}.
- prog_len  input  5  number of slots to execute from slot 0, 0..IMEM_DEPTH; sampled with start.
- start  input  1  begin execution; honoured only in IDLE.
- rs1  output  4  source register 1 to pipeline.
- rs2  output  4  source register 2 to pipeline.
- rd  output  4  destination register to pipeline.
- func  output  4  ALU function code to pipeline.
- addr  output  8  memory write address to pipeline.
- issue_valid  output  1  fields carry a real instruction this cycle.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  one-cycle pulse when the program has fully retired.
- stall_cnt  output  8  bubbles inserted in the current run; saturates at 255.

Behaviour:
- Reset (asynchronous, any state, mid-run included):
  - state=IDLE; pc=0.
  - rs1/rs2/rd/func/addr=0; issue_valid=0; busy=0; done=0; stall_cnt=0.
  - Scoreboard cleared. Instruction memory contents are not reset.
- All outputs are registered.
- States:
  - IDLE:
    - load_en writes imem[load_addr] at the edge.
    - start with prog_len>0: pc=0, stall_cnt=0, go to RUN.
    - start with prog_len=0: done=1 for one cycle, stay IDLE.
    - If start and load_en are both high, the load completes and start is honoured.
  - RUN, each cycle, evaluating imem[pc]:
    - Hazard when rs1 or rs2 equals the rd of any instruction issued in the previous LAT-1 cycles.
    - No hazard: next cycle the fields equal imem[pc], issue_valid=1, pc increments.
    - Hazard: next cycle issue_valid=0, fields hold their previous values, stall_cnt increments, pc holds.
    - After the issue of slot prog_len-1, go to DRAIN.
  - DRAIN:
    - issue_valid=0; a countdown of 3 cycles covers the pipeline depth after the ALU stage.
    - Then go to IDLE and pulse done=1 for exactly one cycle; busy drops in the same cycle.
- Scoreboard:
  - LAT-1 entry shift register of {valid, rd}. It shifts every cycle in RUN.
  - A bubble enters as an invalid entry. It is cleared on entry to RUN.
- Register 0 gets no special treatment; it is compared like any other register.
- start, load_en and a changed prog_len are ignored while busy.
- prog_len > IMEM_DEPTH is clamped to IMEM_DEPTH.
- Back-to-back independent instructions issue on consecutive cycles; issue_valid stays continuously high.

Test Plan:
- Independent run: load {3,5,10,0,125}, {3,8,12,2,126}, {7,3,13,11,127}; prog_len=3; start -> issue_valid high for 3 consecutive cycles with fields in slot order; stall_cnt=0; done pulses 4 cycles after the last issue.
- RAW hazard: slot0 {3,5,10,0,125}, slot1 {10,5,14,1,128} -> slot1 issues exactly 3 cycles after slot0 with two issue_valid=0 bubbles; stall_cnt=2.
- Hazard on rs2 plus a non-adjacent dependency: slot0 rd=12, slot1 independent, slot2 {12,13,15,0,130} with slot1 rd=13 -> slot2 delayed until 3 cycles after slot1 issue; stall_cnt=2.
- Boundaries:
  - prog_len=0 with start -> done pulse next cycle, issue_valid never high.
  - prog_len=16 runs all slots.
  - load_en and start pulsed during RUN -> ignored; imem unchanged.
- Reset mid-RUN after 2 issues -> all outputs 0 immediately without a clock edge. A subsequent start reruns from slot 0 using the retained imem.

Source files
------------

// File: rtl/pipe_issue_unit.sv
// pipe_issue_unit
//   Instruction issue front-end for the 4-stage register/ALU/memory pipeline.
//   Holds a small program, issues at most one instruction per clock, inserts
//   bubbles on read-after-write hazards and pulses done once the last
//   instruction has retired.
// Ports:
//   clk1, rst                 clock, async active-high reset
//   load_en/load_addr/data    program one slot (IDLE only)
//   prog_len, start           run slots 0..prog_len-1 (IDLE only)
//   rs1/rs2/rd/func/addr      registered instruction fields to the pipeline
//   issue_valid               fields carry a real instruction this cycle
//   busy, done                run status; done is a one-cycle pulse
//   stall_cnt                 bubbles in the current run, saturating
module pipe_issue_unit #(
  parameter int IMEM_DEPTH = 16,
  parameter int LAT        = 3
) (
  input  logic                          clk1,
  input  logic                          rst,
  input  logic                          load_en,
  input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
  input  logic [23:0]                   load_data,
  input  logic [$clog2(IMEM_DEPTH):0]   prog_len,
  input  logic                          start,
  output logic [3:0]                    rs1,
  output logic [3:0]                    rs2,
  output logic [3:0]                    rd,
  output logic [3:0]                    func,
  output logic [7:0]                    addr,
  output logic                          issue_valid,
  output logic                          busy,
  output logic                          done,
  output logic [7:0]                    stall_cnt
);

  localparam int AW   = $clog2(IMEM_DEPTH);
  localparam int LW   = AW + 1;
  // At least one entry so the arrays stay legal when LAT == 1.
  localparam int SB_N = (LAT > 1) ? LAT - 1 : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  logic [23:0] imem [IMEM_DEPTH];

  state_t               state_q, state_d;
  logic [AW-1:0]        pc_q, pc_d;
  logic [LW-1:0]        len_q, len_d;
  logic [1:0]           drain_q, drain_d;
  logic [SB_N-1:0]      sb_v_q, sb_v_d;
  logic [SB_N-1:0][3:0] sb_rd_q, sb_rd_d;
  logic [23:0]          fields_q, fields_d;
  logic                 issue_valid_q, issue_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [7:0]           stall_cnt_q, stall_cnt_d;

  logic [23:0]   cur;
  logic          hazard;
  logic          last_slot;
  logic [LW-1:0] len_clamped;

  // Program memory is deliberately not reset so a program survives rst.
  always_ff @(posedge clk1) begin
    if (load_en && state_q == S_IDLE) imem[load_addr] <= load_data;
  end

  always_comb begin
    cur         = imem[pc_q];
    len_clamped = (prog_len > LW'(IMEM_DEPTH)) ? LW'(IMEM_DEPTH) : prog_len;
    last_slot   = ({1'b0, pc_q} == len_q - LW'(1));

    hazard = 1'b0;
    if (LAT > 1) begin
      for (int unsigned i = 0; i < SB_N; i++) begin
        if (sb_v_q[i] && (sb_rd_q[i] == cur[23:20] || sb_rd_q[i] == cur[19:16]))
          hazard = 1'b1;
      end
    end

    state_d       = state_q;
    pc_d          = pc_q;
    len_d         = len_q;
    drain_d       = drain_q;
    sb_v_d        = sb_v_q;
    sb_rd_d       = sb_rd_q;
    fields_d      = fields_q;
    issue_valid_d = 1'b0;
    done_d        = 1'b0;
    stall_cnt_d   = stall_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_clamped == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = S_RUN;
            pc_d        = '0;
            len_d       = len_clamped;
            stall_cnt_d = '0;
            sb_v_d      = '0;
          end
        end
      end
      S_RUN: begin
        // Entry 0 records this cycle's decision; a bubble shifts in invalid.
        for (int unsigned i = 1; i < SB_N; i++) begin
          sb_v_d[i]  = sb_v_q[i-1];
          sb_rd_d[i] = sb_rd_q[i-1];
        end
        sb_v_d[0]  = ~hazard;
        sb_rd_d[0] = cur[15:12];
        if (hazard) begin
          if (stall_cnt_q != 8'hFF) stall_cnt_d = stall_cnt_q + 8'd1;
        end else begin
          fields_d      = cur;
          issue_valid_d = 1'b1;
          pc_d          = pc_q + AW'(1);
          if (last_slot) begin
            state_d = S_DRAIN;
            drain_d = 2'd3;
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == 2'd0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q - 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      len_q         <= '0;
      drain_q       <= '0;
      sb_v_q        <= '0;
      sb_rd_q       <= '0;
      fields_q      <= '0;
      issue_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      len_q         <= len_d;
      drain_q       <= drain_d;
      sb_v_q        <= sb_v_d;
      sb_rd_q       <= sb_rd_d;
      fields_q      <= fields_d;
      issue_valid_q <= issue_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign rs1         = fields_q[23:20];
  assign rs2         = fields_q[19:16];
  assign rd          = fields_q[15:12];
  assign func        = fields_q[11:8];
  assign addr        = fields_q[7:0];
  assign issue_valid = issue_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_issue_unit.sv
module tb_pipe_issue_unit;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [23:0] load_data;
  logic [4:0]  prog_len;
  logic        start;
  logic [3:0]  rs1, rs2, rd, func;
  logic [7:0]  addr;
  logic        issue_valid, busy, done;
  logic [7:0]  stall_cnt;

  int errors = 0;
  int checks = 0;

  logic [23:0] iss [32];
  int          iss_cyc [32];
  int          n, done_cyc, bad_busy;

  pipe_issue_unit #(.IMEM_DEPTH(16), .LAT(3)) dut (
    .clk1(clk1), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .prog_len(prog_len), .start(start),
    .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .addr(addr),
    .issue_valid(issue_valid), .busy(busy), .done(done), .stall_cnt(stall_cnt)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  function automatic logic [23:0] fields();
    return {rs1, rs2, rd, func, addr};
  endfunction

  function automatic logic [23:0] slot_word(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {4'd1, 4'd2, 4'd15, b[3:0], b};
  endfunction

  task automatic load(input int slot, input logic [23:0] data);
    load_en   = 1'b1;
    load_addr = slot[3:0];
    load_data = data;
    tick();
    load_en   = 1'b0;
  endtask

  // Starts a run and records every issued instruction and its cycle index
  // (cycle 1 = first edge after the start edge) until done or a cycle budget.
  task automatic run_prog(input logic [4:0] len, input bit inject,
                          output int n_o, output int done_o, output int bad_o);
    prog_len = len;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    prog_len = 5'd7;
    n_o = 0; done_o = -1; bad_o = 0;
    for (int c = 1; c <= 300; c++) begin
      if (inject && c == 2) begin
        load_en = 1'b1; load_addr = 4'd1; load_data = 24'hFFFFFF; start = 1'b1;
      end
      tick();
      load_en = 1'b0;
      start   = 1'b0;
      if (issue_valid && n_o < 32) begin
        iss[n_o] = fields();
        iss_cyc[n_o] = c;
        n_o++;
      end
      if (done) begin
        done_o = c;
        break;
      end
      if (!busy) bad_o++;
    end
    chk("done_reached", 32'(done_o > 0), 1);
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    prog_len = '0; start = 1'b0;
    tick(); tick();
    chk("rst_fields", 32'(fields()), 0);
    chk("rst_valid", 32'(issue_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    rst = 1'b0;
    tick();

    // Independent program
    load(0, 24'h35A07D); load(1, 24'h38C27E); load(2, 24'h73DB7F);
    run_prog(5'd3, 1'b0, n, done_cyc, bad_busy);
    chk("ind_n", 32'(n), 3);
    chk("ind_s0", 32'(iss[0]), 32'h35A07D);
    chk("ind_s1", 32'(iss[1]), 32'h38C27E);
    chk("ind_s2", 32'(iss[2]), 32'h73DB7F);
    chk("ind_cyc0", 32'(iss_cyc[0]), 1);
    chk("ind_cyc2", 32'(iss_cyc[2]), 3);
    chk("ind_done_lat", 32'(done_cyc - iss_cyc[2]), 4);
    chk("ind_busy", 32'(bad_busy), 0);
    chk("ind_busy_drop", 32'(busy), 0);
    chk("ind_stall", 32'(stall_cnt), 0);
    tick();
    chk("done_pulse_one", 32'(done), 0);

    // RAW hazard on rs1
    load(1, 24'hA5E180);
    run_prog(5'd2, 1'b0, n, done_cyc, bad_busy);
    chk("raw_n", 32'(n), 2);
    chk("raw_gap", 32'(iss_cyc[1] - iss_cyc[0]), 3);
    chk("raw_s1", 32'(iss[1]), 32'hA5E180);
    chk("raw_stall", 32'(stall_cnt), 2);

    // Hazard on rs2 plus non-adjacent dependency
    load(0, 24'h12C001); load(1, 24'h45D002); load(2, 24'hCDF082);
    run_prog(5'd3, 1'b0, n, done_cyc, bad_busy);
    chk("rs2_n", 32'(n), 3);
    chk("rs2_gap01", 32'(iss_cyc[1] - iss_cyc[0]), 1);
    chk("rs2_gap12", 32'(iss_cyc[2] - iss_cyc[1]), 3);
    chk("rs2_s2", 32'(iss[2]), 32'hCDF082);
    chk("rs2_stall", 32'(stall_cnt), 2);

    // prog_len = 0
    prog_len = 5'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("len0_done", 32'(done), 1);
    chk("len0_valid", 32'(issue_valid), 0);
    chk("len0_busy", 32'(busy), 0);
    tick();
    chk("len0_done_drop", 32'(done), 0);
    chk("len0_valid2", 32'(issue_valid), 0);

    // Full 16-slot program, then an over-length request clamped to 16
    for (int i = 0; i < 16; i++) load(i, slot_word(i));
    run_prog(5'd16, 1'b0, n, done_cyc, bad_busy);
    chk("full_n", 32'(n), 16);
    chk("full_span", 32'(iss_cyc[15] - iss_cyc[0]), 15);
    chk("full_s0", 32'(iss[0]), 32'(slot_word(0)));
    chk("full_s15", 32'(iss[15]), 32'(slot_word(15)));
    chk("full_stall", 32'(stall_cnt), 0);
    run_prog(5'd31, 1'b0, n, done_cyc, bad_busy);
    chk("clamp_n", 32'(n), 16);

    // load_en/start during RUN are ignored
    run_prog(5'd3, 1'b1, n, done_cyc, bad_busy);
    chk("inj_n", 32'(n), 3);
    chk("inj_s1", 32'(iss[1]), 32'(slot_word(1)));
    run_prog(5'd2, 1'b0, n, done_cyc, bad_busy);
    chk("inj_imem", 32'(iss[1]), 32'(slot_word(1)));

    // Asynchronous reset mid-run after two issues
    prog_len = 5'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("mid_valid_pre", 32'(issue_valid), 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_fields", 32'(fields()), 0);
    chk("arst_valid", 32'(issue_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_stall", 32'(stall_cnt), 0);
    chk("arst_done", 32'(done), 0);
    tick();
    rst = 1'b0;
    tick();
    run_prog(5'd3, 1'b0, n, done_cyc, bad_busy);
    chk("rerun_n", 32'(n), 3);
    chk("rerun_s0", 32'(iss[0]), 32'(slot_word(0)));
    chk("rerun_cyc0", 32'(iss_cyc[0]), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
